modulo_deposito_rolhas: RTL and testbench
=========================================

# modulo_deposito_rolhas

Responder side of the cork-transfer handshake in the bottle filling/sealing line. The block owns the secondary cork depot (0..99 corks). It serves two requesters:
- **Transfer:** a batch request from the sealing line's main cork buffer. The block grants it by emitting one `transfer_pulse` per cork, which feeds the main buffer's up-counter.
- **Load:** an operator load request that adds a quantity to the depot.

The block also exports the stock count used by the display encoders.

## Interface
Parameters:
- `WIDTH`, 7: stock and quantity width.
- `CAP`, 99: maximum depot stock. Bounded by the two-digit display.
- `BATCH`, 20: corks delivered per granted transfer.

Ports:
- `clk`  in  1: system (divided) clock. All state changes on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_transfer`  in  1: level request from the main line. Held until `ack_transfer` or `nak_transfer`, then dropped (4-phase).
- `ack_transfer`  out  1: batch fully delivered. Held until `req_transfer` falls.
- `nak_transfer`  out  1: stock < `BATCH` at grant time. Held until `req_transfer` falls.
- `transfer_pulse`  out  1: high one cycle per delivered cork.
- `load_valid`  in  1: operator load request, qualified by `load_ready`.
- `load_qty`  in  `WIDTH`: corks offered by the operator.
- `load_ready`  out  1: block can accept a load this cycle.
- `load_accept`  out  1: one-cycle pulse, load applied.
- `load_reject`  out  1: one-cycle pulse, load would exceed `CAP`. Stock unchanged.
- `stock`  out  `WIDTH`: current depot count.
- `empty`  out  1: `stock == 0`.
- `low`  out  1: `stock < BATCH`.
- `estado`  out  2: FSM state code.

## Operation
- FSM states:
  - IDLE = 00
  - TRANSFER = 01
  - DONE = 10
  - NAK = 11
- Every output is a registered state or pulse flag. There are no combinational paths from input to output.
- **IDLE:**
  - `load_ready` = !`req_transfer`.
  - If `req_transfer` = 1 and `stock` >= `BATCH`: load the remaining-count register with `BATCH`, go to TRANSFER.
  - If `req_transfer` = 1 and `stock` < `BATCH`: go to NAK.
  - Else if `load_valid` = 1: compute the (`WIDTH`+1)-bit sum `stock` + `load_qty`.
    - Sum <= `CAP`: `stock` <= sum, pulse `load_accept`.
    - Sum > `CAP`: pulse `load_reject`.
    - Either way, stay in IDLE.
- **TRANSFER:**
  - Each cycle: `transfer_pulse` = 1, `stock` decrements by 1, remaining decrements by 1.
  - When remaining reaches 0 after the last decrement, go to DONE.
  - Loads are not accepted (`load_ready` = 0).
  - `req_transfer` dropping early does not abort. The batch always completes.
- **DONE:** `ack_transfer` = 1. Go to IDLE on the first cycle `req_transfer` = 0.
- **NAK:** `nak_transfer` = 1. Go to IDLE on the first cycle `req_transfer` = 0. Stock unchanged.
- **Priority:** transfer request over load. If both arrive in the same IDLE cycle, the load is not consumed; the operator side retries.
- **Arithmetic:**
  - Stock never wraps. The decrement is guarded by the >= `BATCH` entry check.
  - `load_qty` = 0 is accepted and leaves stock unchanged.
  - `load_qty` values above `CAP` are always rejected.

## Timing
- **Reset values:**
  - FSM state: IDLE.
  - `stock`: 0.
  - Remaining-count register: 0.
  - All pulse and handshake outputs: 0.
  - `empty`: 1. `low`: 1. `load_ready`: 1.
- **Reset mid-TRANSFER:** pulses stop in the next cycle and `stock` reads 0. Corks already pulsed stay delivered; no rollback.
- **Transfer latency:** request sampled high in IDLE at edge k gives:
  - `transfer_pulse` high for cycles k+1 .. k+`BATCH`.
  - `ack_transfer` high from cycle k+`BATCH`+1.
- **Release:** `req_transfer` low at edge m returns the FSM to IDLE at m+1. A new request is sampled no earlier than edge m+1.
- **NAK latency:** `nak_transfer` rises one cycle after the request is sampled.
- **Load latency:** `load_accept` or `load_reject` is high exactly one cycle, at the cycle after the `load_valid` sample. `stock` updates on the same edge.
- **Derived flags:** `empty` and `low` are registered from the updated stock value, so they track `stock` on the same cycle.

## Test plan
- Reset, then load 50 -> `load_accept` one cycle, `stock` = 50, `low` = 0, `empty` = 0.
- With stock 50, assert `req_transfer` -> exactly 20 `transfer_pulse` cycles, `stock` = 30, `ack_transfer` held until req drops, then IDLE (`estado` = 00).
- With stock 15, assert `req_transfer` -> no pulses, `nak_transfer` = 1, `stock` stays 15.
- With stock 90, load 10 -> `load_reject`, `stock` = 90. Then load 9 -> `load_accept`, `stock` = 99.
- `req_transfer` and `load_valid` (qty 5) in the same cycle with stock 40 -> transfer wins, `load_ready` = 0 for the whole batch. Retried load after ack/release -> `stock` = 25.
- Assert `reset` after the 7th pulse of a batch -> no further pulses, `stock` = 0, `estado` = 00, `ack_transfer` never asserted.

Source files
------------

// File: rtl/modulo_deposito_rolhas.sv
// Secondary cork depot: answers batch transfer requests from the main cork
// buffer with one pulse per cork, and accepts operator loads up to CAP.
// Every output is driven straight from a register.
module modulo_deposito_rolhas #(
    parameter int WIDTH = 7,
    parameter int CAP   = 99,
    parameter int BATCH = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_transfer,
    output logic             ack_transfer,
    output logic             nak_transfer,
    output logic             transfer_pulse,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_qty,
    output logic             load_ready,
    output logic             load_accept,
    output logic             load_reject,
    output logic [WIDTH-1:0] stock,
    output logic             empty,
    output logic             low,
    output logic [1:0]       estado
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        TRANSFER = 2'b01,
        DONE     = 2'b10,
        NAK      = 2'b11
    } state_t;

    localparam logic [WIDTH-1:0] BATCH_W = WIDTH'(BATCH);
    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
    localparam logic [WIDTH:0]   CAP_W   = (WIDTH+1)'(CAP);

    state_t           state, state_n;
    logic [WIDTH-1:0] rem, rem_n;
    logic [WIDTH-1:0] stock_n;
    logic [WIDTH:0]   sum;
    logic             accept_n, reject_n;

    assign estado = state;

    // Next-state and datapath decisions; a request in IDLE always wins over a load.
    always_comb begin
        state_n  = state;
        rem_n    = rem;
        stock_n  = stock;
        accept_n = 1'b0;
        reject_n = 1'b0;
        // one extra bit so an oversized load cannot wrap into an accept
        sum      = {1'b0, stock} + {1'b0, load_qty};
        case (state)
            IDLE: begin
                if (req_transfer) begin
                    if (stock >= BATCH_W) begin
                        rem_n   = BATCH_W;
                        state_n = TRANSFER;
                    end else begin
                        state_n = NAK;
                    end
                end else if (load_valid) begin
                    if (sum <= CAP_W) begin
                        stock_n  = sum[WIDTH-1:0];
                        accept_n = 1'b1;
                    end else begin
                        reject_n = 1'b1;
                    end
                end
            end
            TRANSFER: begin
                // entry check guarantees stock >= rem, so this never wraps
                stock_n = stock - ONE_W;
                rem_n   = rem - ONE_W;
                if (rem == ONE_W) state_n = DONE;
            end
            DONE, NAK: begin
                if (!req_transfer) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State, counters and all output flags, registered from the next-state values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            rem            <= '0;
            stock          <= '0;
            transfer_pulse <= 1'b0;
            ack_transfer   <= 1'b0;
            nak_transfer   <= 1'b0;
            load_accept    <= 1'b0;
            load_reject    <= 1'b0;
            empty          <= 1'b1;
            low            <= 1'b1;
            load_ready     <= 1'b1;
        end else begin
            state          <= state_n;
            rem            <= rem_n;
            stock          <= stock_n;
            transfer_pulse <= (state_n == TRANSFER);
            ack_transfer   <= (state_n == DONE);
            nak_transfer   <= (state_n == NAK);
            load_accept    <= accept_n;
            load_reject    <= reject_n;
            empty          <= (stock_n == '0);
            low            <= (stock_n < BATCH_W);
            // sampled copy of the IDLE readiness rule, kept registered
            load_ready     <= (state_n == IDLE) && !req_transfer;
        end
    end

endmodule

// File: tb/tb_modulo_deposito_rolhas.sv
// Transaction-level bench for the cork depot: a plain stock counter predicts
// load outcomes and batch results; cycle timing is checked against fixed latencies.
module tb_modulo_deposito_rolhas;

    localparam int WIDTH = 7;
    localparam int CAP   = 99;
    localparam int BATCH = 20;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_transfer;
    logic             ack_transfer;
    logic             nak_transfer;
    logic             transfer_pulse;
    logic             load_valid;
    logic [WIDTH-1:0] load_qty;
    logic             load_ready;
    logic             load_accept;
    logic             load_reject;
    logic [WIDTH-1:0] stock;
    logic             empty;
    logic             low;
    logic [1:0]       estado;

    int total = 0;
    int bad   = 0;
    int m_stock = 0;

    modulo_deposito_rolhas #(.WIDTH(WIDTH), .CAP(CAP), .BATCH(BATCH)) dut (
        .clk(clk), .reset(reset),
        .req_transfer(req_transfer), .ack_transfer(ack_transfer),
        .nak_transfer(nak_transfer), .transfer_pulse(transfer_pulse),
        .load_valid(load_valid), .load_qty(load_qty), .load_ready(load_ready),
        .load_accept(load_accept), .load_reject(load_reject),
        .stock(stock), .empty(empty), .low(low), .estado(estado)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags();
        chk("stock", 32'(stock), 32'(m_stock));
        chk("empty", 32'(empty), 32'(m_stock == 0));
        chk("low",   32'(low),   32'(m_stock < BATCH));
    endtask

    task automatic do_load(input int qty);
        bit acc;
        chk("ld_ready", 32'(load_ready), 1);
        load_valid = 1'b1;
        load_qty   = WIDTH'(qty);
        tick();
        load_valid = 1'b0;
        acc = (m_stock + qty <= CAP);
        chk("ld_accept", 32'(load_accept), 32'(acc));
        chk("ld_reject", 32'(load_reject), 32'(!acc));
        if (acc) m_stock += qty;
        check_flags();
        tick();
        chk("ld_accept_1cyc", 32'(load_accept), 0);
        chk("ld_reject_1cyc", 32'(load_reject), 0);
    endtask

    // drop_at: cycle index at which req is released early (0 = hold until done)
    // rst_at : pulse count after which reset is asserted (0 = none)
    task automatic do_transfer(input bit with_load, input int lq, input int drop_at, input int rst_at);
        int  pulses = 0;
        int  done_at = 0;
        int  first_pulse = 0;
        int  i = 0;
        bit  grant;
        bit  lr_bad = 0;
        bit  saw_ld = 0;
        int  extra_p;
        int  extra_a;
        grant = (m_stock >= BATCH);
        req_transfer = 1'b1;
        if (with_load) begin
            load_valid = 1'b1;
            load_qty   = WIDTH'(lq);
        end
        while (done_at == 0 && i < 40) begin
            tick();
            i++;
            load_valid = 1'b0;
            if (transfer_pulse) begin
                pulses++;
                if (first_pulse == 0) first_pulse = i;
                if (load_ready) lr_bad = 1;
                chk("stock_mid", 32'(stock), 32'(m_stock - pulses + 1));
            end
            if (load_accept || load_reject) saw_ld = 1;
            if (ack_transfer || nak_transfer) done_at = i;
            if (rst_at != 0 && pulses == rst_at) begin
                reset = 1'b1;
                req_transfer = 1'b0;
                tick();
                reset = 1'b0;
                chk("rst_pulse", 32'(transfer_pulse), 0);
                chk("rst_estado", 32'(estado), 0);
                chk("rst_ack", 32'(ack_transfer), 0);
                m_stock = 0;
                check_flags();
                extra_p = 0;
                extra_a = 0;
                for (int k = 0; k < 25; k++) begin
                    tick();
                    if (transfer_pulse) extra_p++;
                    if (ack_transfer) extra_a++;
                end
                chk("rst_no_pulses", 32'(extra_p), 0);
                chk("rst_no_ack", 32'(extra_a), 0);
                return;
            end
            if (drop_at != 0 && i == drop_at) req_transfer = 1'b0;
        end
        if (done_at == 0) begin
            $display("FAIL xfer_timeout: got no ack/nak within 40 cycles");
            bad++;
            total++;
        end
        chk("pulses", 32'(pulses), grant ? BATCH : 0);
        chk("first_pulse", 32'(first_pulse), grant ? 1 : 0);
        chk("done_at", 32'(done_at), grant ? BATCH + 1 : 1);
        chk("ack", 32'(ack_transfer), 32'(grant));
        chk("nak", 32'(nak_transfer), 32'(!grant));
        chk("ready_busy", 32'(lr_bad), 0);
        if (with_load) chk("ld_ignored", 32'(saw_ld), 0);
        if (grant) m_stock -= BATCH;
        check_flags();
        if (req_transfer) begin
            for (int k = 0; k < 2; k++) begin
                tick();
                chk("ack_held", 32'(ack_transfer), 32'(grant));
                chk("nak_held", 32'(nak_transfer), 32'(!grant));
            end
            req_transfer = 1'b0;
        end
        tick();
        chk("rel_estado", 32'(estado), 0);
        chk("rel_ack", 32'(ack_transfer), 0);
        chk("rel_nak", 32'(nak_transfer), 0);
        chk("rel_ready", 32'(load_ready), 1);
        check_flags();
    endtask

    initial begin
        int op;
        int q;
        int d;
        reset = 1'b1;
        req_transfer = 1'b0;
        load_valid = 1'b0;
        load_qty = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_estado", 32'(estado), 0);
        chk("rst_ready", 32'(load_ready), 1);
        chk("rst_ack", 32'(ack_transfer), 0);
        chk("rst_nak", 32'(nak_transfer), 0);
        chk("rst_pulse", 32'(transfer_pulse), 0);
        chk("rst_acc", 32'(load_accept), 0);
        chk("rst_rej", 32'(load_reject), 0);
        check_flags();

        do_load(50);                 // 50
        do_transfer(0, 0, 0, 0);     // 30
        do_transfer(0, 0, 0, 0);     // 10
        do_load(5);                  // 15
        do_transfer(0, 0, 0, 0);     // nak, 15
        do_load(75);                 // 90
        do_load(10);                 // reject
        do_load(9);                  // 99
        do_load(0);                  // accepted, unchanged
        do_load(1);                  // reject at full
        do_transfer(0, 0, 5, 0);     // early release, 79
        do_transfer(0, 0, 0, 0);     // 59
        do_transfer(0, 0, 0, 0);     // 39
        do_load(1);                  // 40
        do_transfer(1, 5, 0, 0);     // transfer wins, 20
        do_load(5);                  // 25
        do_transfer(0, 0, 0, 7);     // reset after 7th pulse -> 0
        do_load(127);                // oversized, reject
        do_load(99);                 // exactly CAP from 0

        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 2);
            if (op == 0) begin
                q = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 40);
                do_load(q);
            end else begin
                d = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : 0;
                do_transfer(($urandom_range(0, 3) == 0), $urandom_range(0, 30), d, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
